mux_pair_arbiter: RTL
=====================

# mux_pair_arbiter

Sequential front end for the 4-bit 2:1 mux (`four_bit_mux`). It arbitrates between two 4-bit producer channels with valid/ready handshakes and drives the mux `a`, `b` and `sel` inputs. It registers the mux output `y` into a one-entry output buffer for the downstream consumer. It also checks each captured `y` against the granted source data and keeps per-source transfer counts.

## Interface
Parameters:
- `CNT_W`, 8 — width of the per-source saturating transfer counters.

Ports (one clock; reset is synchronous and active-high):
- `clk`  input  1  — the single clock; all state updates on its rising edge.
- `rst`  input  1  — synchronous, active-high reset.
- `a_valid`  input  1  — source A has data.
- `a_data`  input  4  — source A data.
- `a_ready`  output  1  — source A transfer accepted this cycle.
- `b_valid`  input  1  — source B has data.
- `b_data`  input  4  — source B data.
- `b_ready`  output  1  — source B transfer accepted this cycle.
- `mux_a`  output  4  — to mux `a`; equals `a_data` combinationally.
- `mux_b`  output  4  — to mux `b`; equals `b_data` combinationally.
- `mux_sel`  output  1  — to mux `sel`. 0 selects `a`, 1 selects `b`.
- `mux_y`  input  4  — from mux `y`.
- `out_valid`  output  1  — output buffer holds data.
- `out_ready`  input  1  — consumer accepts the output.
- `out_data`  output  4  — captured mux output.
- `out_src`  output  1  — source of `out_data`: 0 = A, 1 = B.
- `cnt_a`  output  `CNT_W`  — accepted A transfers, saturating.
- `cnt_b`  output  `CNT_W`  — accepted B transfers, saturating.
- `err`  output  1  — sticky mismatch flag.

## Operation
- **Free condition:** `can_accept = !out_valid || out_ready`.
- **Arbitration (combinational):**
  - Only `a_valid` asserted: grant A.
  - Only `b_valid` asserted: grant B.
  - Both asserted: grant the source opposite `last_grant` (round-robin).
  - Neither asserted: no grant.
- **Ready outputs:** `a_ready = grant_A && can_accept`; `b_ready = grant_B && can_accept`. At most one is high in any cycle. A ready is never asserted without the matching valid.
- **Select:** `mux_sel = 1` only when B is granted. Otherwise `mux_sel = 0`, including when idle.
- **Transfer:** occurs on any cycle with `a_ready` or `b_ready` high. At that clock edge:
  - `out_data <= mux_y`
  - `out_src <=` granted source
  - `out_valid <= 1`
  - `last_grant <=` granted source
  - the granted source's counter increments, unless it is already at `2^CNT_W-1`, where it holds.
- **Drain:** `out_valid && out_ready` with no new transfer: `out_valid <= 0`. `out_data` and `out_src` hold their last values.
- **Simultaneous drain and transfer:** the new data is loaded and `out_valid` stays 1, giving full throughput of one transfer per cycle.
- **Output stability:** while `out_valid && !out_ready`, `out_data` and `out_src` hold. Both ready outputs are 0, so no transfer occurs.
- **Check:** on each transfer, if `mux_y` differs from the granted source data, `err <= 1`. `err` is cleared only by `rst`.

## Timing
- **Reset:** `rst` high at a rising edge sets:
  - `out_valid = 0`, `out_data = 0`, `out_src = 0`
  - `cnt_a = 0`, `cnt_b = 0`, `err = 0`
  - `last_grant = B`, so A wins the first contention.
- **During reset:** while `rst` is high, `a_ready = b_ready = 0` and `mux_sel = 0`. Reset mid-operation discards any buffered output with no drain.
- **Latency:** one cycle. Data accepted at edge N appears on `out_data` with `out_valid = 1` immediately after edge N.
- **Combinational paths:** the mux is combinational, and `mux_y` must settle within the same cycle as `mux_sel`. The paths `a_valid/b_valid/out_ready → a_ready/b_ready/mux_sel` are combinational. Nothing is combinational from `mux_y` to any output except through registers.
- **Sustained throughput:** with `out_ready` held high and both sources valid, grants alternate A, B, A, B… on consecutive cycles.
- **Counter saturation:** a counter at 255 (with `CNT_W = 8`) stays at 255 on further transfers. The other counter is unaffected.

## Test plan
- **Reset:** hold `rst` 2 cycles with both valids high → `out_valid = 0`, readies 0, counters 0, `err = 0`. On the first cycle after release, `a_ready = 1` and `mux_sel = 0`.
- **Contention with consumer always ready:** `a_data = 4'h3`, `b_data = 4'hC`, both valid 4 cycles, `out_ready = 1` → `out_data` sequence 3, C, 3, C with `out_src` 0, 1, 0, 1. `cnt_a = 2`, `cnt_b = 2`.
- **Backpressure:** `out_ready = 0` after the first transfer of `a_data = 4'h5`, with `b_valid` high → `out_data` holds 5 and both readies are 0. When `out_ready` rises, that same cycle `b_ready = 1`, and the next `out_data` is the B data.
- **Error detection:** force `mux_y` to `4'hF` while `a_data = 4'h1` is granted → `err = 1` one cycle later. `err` stays 1 through later correct transfers and clears only on `rst`.
- **Saturation:** 260 consecutive A-only transfers → `cnt_a = 255`, `cnt_b = 0`.
- **Reset mid-operation:** assert `rst` with `out_valid = 1` and `out_ready = 0` → the next cycle has `out_valid = 0`, `out_data = 0`, and counters at 0.

Source files
------------

// File: rtl/mux_pair_arbiter.sv
// Round-robin valid/ready front end for a 4-bit 2:1 mux.
// Registers the mux output, checks it against the granted source, counts transfers.
module mux_pair_arbiter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a_valid,
    input  logic [3:0]       a_data,
    output logic             a_ready,
    input  logic             b_valid,
    input  logic [3:0]       b_data,
    output logic             b_ready,
    output logic [3:0]       mux_a,
    output logic [3:0]       mux_b,
    output logic             mux_sel,
    input  logic [3:0]       mux_y,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       out_data,
    output logic             out_src,
    output logic [CNT_W-1:0] cnt_a,
    output logic [CNT_W-1:0] cnt_b,
    output logic             err
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic             out_valid_q, out_valid_d;
    logic [3:0]       out_data_q, out_data_d;
    logic             out_src_q, out_src_d;
    logic             last_grant_q, last_grant_d;
    logic [CNT_W-1:0] cnt_a_q, cnt_a_d;
    logic [CNT_W-1:0] cnt_b_q, cnt_b_d;
    logic             err_q, err_d;

    logic can_accept;
    logic grant_a;
    logic grant_b;
    logic xfer;
    logic [3:0] granted_data;

    // last_grant: 0 = A, 1 = B; contention goes to the other source
    assign can_accept = !out_valid_q || out_ready;
    assign grant_a = !rst && a_valid && (!b_valid || last_grant_q);
    assign grant_b = !rst && b_valid && (!a_valid || !last_grant_q);

    assign a_ready = grant_a && can_accept;
    assign b_ready = grant_b && can_accept;
    assign mux_sel = grant_b;
    assign mux_a   = a_data;
    assign mux_b   = b_data;

    assign xfer         = a_ready || b_ready;
    assign granted_data = b_ready ? b_data : a_data;

    always_comb begin
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_src_d    = out_src_q;
        last_grant_d = last_grant_q;
        cnt_a_d      = cnt_a_q;
        cnt_b_d      = cnt_b_q;
        err_d        = err_q;
        if (xfer) begin
            out_valid_d  = 1'b1;
            out_data_d   = mux_y;
            out_src_d    = b_ready;
            last_grant_d = b_ready;
            if (mux_y != granted_data) begin
                err_d = 1'b1;
            end
            if (a_ready && cnt_a_q != CNT_MAX) begin
                cnt_a_d = cnt_a_q + CNT_ONE;
            end
            if (b_ready && cnt_b_q != CNT_MAX) begin
                cnt_b_d = cnt_b_q + CNT_ONE;
            end
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q  <= 1'b0;
            out_data_q   <= 4'h0;
            out_src_q    <= 1'b0;
            last_grant_q <= 1'b1;
            cnt_a_q      <= '0;
            cnt_b_q      <= '0;
            err_q        <= 1'b0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_src_q    <= out_src_d;
            last_grant_q <= last_grant_d;
            cnt_a_q      <= cnt_a_d;
            cnt_b_q      <= cnt_b_d;
            err_q        <= err_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_src   = out_src_q;
    assign cnt_a     = cnt_a_q;
    assign cnt_b     = cnt_b_q;
    assign err       = err_q;

endmodule
